// File: rtl/als_pkg.sv
// Shared frame geometry, FSM state encoding and frame builder for light_sensor_emu.
package als_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int LEAD_ZEROS  = 4;
    localparam int DATA_BITS   = 8;
    localparam int TRAIL_ZEROS = 4;
    localparam int CNT_BITS    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } als_state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] level);
        return {{LEAD_ZEROS{1'b0}}, level, {TRAIL_ZEROS{1'b0}}};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses; flops reset to 1 (idle CS level).
// ready goes high once the chain holds only real samples of din.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ready
);

    logic [SYNC_STAGES-1:0] stage_p;
    logic [SYNC_STAGES-1:0] vld_p;
    logic                   prev_p;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            stage_p <= '1;
            vld_p   <= '0;
            prev_p  <= 1'b1;
        end else begin
            stage_p <= {stage_p[SYNC_STAGES-2:0], din};
            vld_p   <= {vld_p[SYNC_STAGES-2:0], 1'b1};
            prev_p  <= stage_p[SYNC_STAGES-1];
        end
    end

    assign level = stage_p[SYNC_STAGES-1];
    assign rise  = ~prev_p & level;
    assign fall  = prev_p & ~level;
    assign ready = vld_p[SYNC_STAGES-1];

endmodule

// File: rtl/light_sensor_emu.sv
// SPI-style light sensor emulator: shifts {4'b0, light_level, 4'b0} out MSB first on SCK falls.
// Optional completed-frame counter enabled by macro ALS_FRAME_CNT_EN.
module light_sensor_emu
    import als_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  CS,
    input  logic                  SCK,
    input  logic [DATA_BITS-1:0]  light_level,
    output logic                  SDO,
    output logic                  sdo_oe,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic [15:0]           frame_cnt
);

    logic cs_level, cs_rise, cs_fall, cs_ready;
    logic sck_level, sck_rise, sck_fall, sck_ready;
    logic sck_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (CS),
        .level  (cs_level),
        .rise   (cs_rise),
        .fall   (cs_fall),
        .ready  (cs_ready)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .din    (SCK),
        .level  (sck_level),
        .rise   (sck_rise),
        .fall   (sck_fall),
        .ready  (sck_ready)
    );

    // The master samples on SCK rises, so only falls move the shifter.
    assign sck_unused = sck_rise | sck_level;

    als_state_t              state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   shreg_next;
    logic [FRAME_BITS-1:0]   load_frame;
    logic [CNT_BITS-1:0]     bit_cnt;
    logic                    armed;
    logic                    shift_edge;

    assign load_frame = build_frame(light_level);
    assign shreg_next = shreg << 1;
    assign shift_edge = sck_fall & sck_ready;

    // armed blocks a frame start until CS has been seen high after reset.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bit_cnt     <= '0;
            SDO         <= 1'b0;
            sdo_oe      <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            armed       <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            if (cs_ready && cs_level)
                armed <= 1'b1;

            case (state)
                IDLE: begin
                    SDO    <= 1'b0;
                    sdo_oe <= 1'b0;
                    if (cs_fall && armed) begin
                        shreg   <= load_frame;
                        SDO     <= load_frame[FRAME_BITS-1];
                        sdo_oe  <= 1'b1;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        frame_abort <= 1'b1;
                        SDO         <= 1'b0;
                        sdo_oe      <= 1'b0;
                    end else if (shift_edge) begin
                        shreg <= shreg_next;
                        if (bit_cnt == CNT_BITS'(FRAME_BITS - 1)) begin
                            state      <= HOLD;
                            frame_done <= 1'b1;
                            SDO        <= 1'b0;
                        end else begin
                            SDO     <= shreg_next[FRAME_BITS-1];
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                HOLD: begin
                    SDO <= 1'b0;
                    if (cs_rise) begin
                        state  <= IDLE;
                        sdo_oe <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    SDO    <= 1'b0;
                    sdo_oe <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALS_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n)
            frame_cnt_r <= '0;
        else if (frame_done)
            frame_cnt_r <= frame_cnt_r + 16'd1;
    end

    assign frame_cnt = frame_cnt_r;
`else
    assign frame_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_light_sensor_emu.sv
// Self-checking bench for light_sensor_emu: directed scenarios plus randomized frames vs. a frame model.
module tb_light_sensor_emu;

    localparam int SS = 2;
`ifdef ALS_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        CS;
    logic        SCK;
    logic [7:0]  light_level;
    logic        SDO;
    logic        sdo_oe;
    logic        frame_done;
    logic        frame_abort;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int completed = 0;

    light_sensor_emu #(.SYNC_STAGES(SS)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .CS          (CS),
        .SCK         (SCK),
        .light_level (light_level),
        .SDO         (SDO),
        .sdo_oe      (sdo_oe),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (frame_done === 1'b1)  done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    function automatic logic [15:0] model_frame(input logic [7:0] lvl);
        return {4'h0, lvl, 4'h0};
    endfunction

    function automatic logic [15:0] model_cnt();
        return CNT_EN ? 16'(completed) : 16'h0000;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Master: CS low, then n SCK periods; SDO captured at each rising edge.
    task automatic xfer(input int nedges, input int half, input int chg_at,
                        input logic [7:0] new_level, output logic [31:0] rx);
        rx = '0;
        @(negedge clk_in);
        CS = 1'b0;
        wait_cyc(half);
        for (int i = 0; i < nedges; i++) begin
            SCK = 1'b1;
            rx  = {rx[30:0], SDO};
            wait_cyc(half);
            SCK = 1'b0;
            if (i + 1 == chg_at) light_level = new_level;
            wait_cyc(half);
        end
    endtask

    task automatic cs_release();
        @(negedge clk_in);
        CS = 1'b1;
        wait_cyc(SS + 6);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; CS = 1'b1; SCK = 1'b0; light_level = 8'h00;
        #1;
        checks++;
        if ({SDO, sdo_oe, frame_done, frame_abort, frame_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got %b%b%b%b %h expected all zero", SDO, sdo_oe, frame_done, frame_abort, frame_cnt);
        end
        wait_cyc(3);
        rst_n = 1'b1;
        completed = 0;
        wait_cyc(10);
        checks++;
        if (sdo_oe !== 1'b0 || SDO !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got oe=%b sdo=%b expected 0 0", sdo_oe, SDO);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rx;
        done_cnt = 0;
        light_level = 8'hA5;
        xfer(16, 50, 0, 8'h00, rx);
        completed++;
        checks++;
        if (rx[15:0] !== model_frame(8'hA5)) begin
            errors++;
            $display("FAIL basic_frame got %h expected %h", rx[15:0], model_frame(8'hA5));
        end
        checks++;
        if (sdo_oe !== 1'b1 || SDO !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold got oe=%b sdo=%b expected 1 0", sdo_oe, SDO);
        end
        cs_release();
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done_count got %0d expected 1", done_cnt);
        end
        checks++;
        if (frame_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL basic_frame_cnt got %h expected %h", frame_cnt, model_cnt());
        end
        checks++;
        if (sdo_oe !== 1'b0) begin
            errors++;
            $display("FAIL basic_oe_release got %b expected 0", sdo_oe);
        end
    endtask

    task automatic test_level_change();
        logic [31:0] rx;
        light_level = 8'h3C;
        xfer(16, 8, 2, 8'hFF, rx);
        completed++;
        cs_release();
        checks++;
        if (rx[15:0] !== 16'h03C0) begin
            errors++;
            $display("FAIL level_change got %h expected 03c0", rx[15:0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx;
        logic [15:0] cnt_before;
        done_cnt = 0; abort_cnt = 0;
        cnt_before = frame_cnt;
        light_level = 8'h5A;
        xfer(7, 8, 0, 8'h00, rx);
        cs_release();
        checks++;
        if (abort_cnt !== 1 || done_cnt !== 0) begin
            errors++;
            $display("FAIL abort_pulses got abort=%0d done=%0d expected 1 0", abort_cnt, done_cnt);
        end
        checks++;
        if (sdo_oe !== 1'b0 || SDO !== 1'b0 || frame_cnt !== cnt_before) begin
            errors++;
            $display("FAIL abort_idle got oe=%b sdo=%b cnt=%h expected 0 0 %h", sdo_oe, SDO, frame_cnt, cnt_before);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] rx;
        done_cnt = 0;
        light_level = 8'h81;
        xfer(20, 8, 0, 8'h00, rx);
        completed++;
        cs_release();
        checks++;
        if (rx[19:0] !== {model_frame(8'h81), 4'h0}) begin
            errors++;
            $display("FAIL overrun_bits got %h expected %h", rx[19:0], {model_frame(8'h81), 4'h0});
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL overrun_done got %0d expected 1", done_cnt);
        end
    endtask

    task automatic test_sdo_latency();
        int lat;
        light_level = 8'hFF;
        @(negedge clk_in);
        CS = 1'b0;
        wait_cyc(8);
        for (int i = 0; i < 4; i++) begin
            SCK = 1'b1;
            wait_cyc(8);
            checks++;
            if (SDO !== 1'b0) begin
                errors++;
                $display("FAIL latency_pre_bit%0d got %b expected 0", i, SDO);
            end
            SCK = 1'b0;
            if (i < 3) wait_cyc(8);
        end
        lat = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_in);
            #1;
            lat++;
            if (SDO === 1'b1) break;
        end
        checks++;
        if (lat !== SS + 1 || SDO !== 1'b1) begin
            errors++;
            $display("FAIL sdo_latency got %0d cycles sdo=%b expected %0d cycles sdo=1", lat, SDO, SS + 1);
        end
        abort_cnt = 0;
        wait_cyc(8);
        cs_release();
        checks++;
        if (abort_cnt !== 1) begin
            errors++;
            $display("FAIL latency_abort got %0d expected 1", abort_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rx;
        abort_cnt = 0;
        light_level = 8'h33;
        xfer(9, 8, 0, 8'h00, rx);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({SDO, sdo_oe, frame_done, frame_abort, frame_cnt} !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %b%b%b%b %h expected all zero", SDO, sdo_oe, frame_done, frame_abort, frame_cnt);
        end
        completed = 0;
        wait_cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cyc(8); SCK = 1'b1;
            wait_cyc(8); SCK = 1'b0;
        end
        wait_cyc(4);
        checks++;
        if (sdo_oe !== 1'b0 || abort_cnt !== 0) begin
            errors++;
            $display("FAIL reset_cs_low_no_start got oe=%b aborts=%0d expected 0 0", sdo_oe, abort_cnt);
        end
        cs_release();
        light_level = 8'h7E;
        xfer(16, 8, 0, 8'h00, rx);
        completed++;
        cs_release();
        checks++;
        if (rx[15:0] !== model_frame(8'h7E) || frame_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL reset_recover got %h cnt=%h expected %h cnt=%h", rx[15:0], frame_cnt, model_frame(8'h7E), model_cnt());
        end
    endtask

    task automatic test_random();
        logic [31:0] rx;
        logic [7:0]  lvl;
        int          half;
        for (int f = 0; f < 6; f++) begin
            done_cnt = 0;
            for (int e = 0; e < 6; e++) begin
                wait_cyc(5); SCK = ~SCK;
            end
            SCK = 1'b0;
            wait_cyc(5);
            checks++;
            if (sdo_oe !== 1'b0 || done_cnt !== 0) begin
                errors++;
                $display("FAIL rand_idle_sck%0d got oe=%b done=%0d expected 0 0", f, sdo_oe, done_cnt);
            end
            lvl  = 8'($urandom);
            half = int'($urandom_range(4, 10));
            light_level = lvl;
            xfer(16, half, int'($urandom_range(1, 15)), 8'($urandom), rx);
            completed++;
            cs_release();
            checks++;
            if (rx[15:0] !== model_frame(lvl) || done_cnt !== 1 || frame_cnt !== model_cnt()) begin
                errors++;
                $display("FAIL rand_frame%0d got %h done=%0d cnt=%h expected %h done=1 cnt=%h",
                         f, rx[15:0], done_cnt, frame_cnt, model_frame(lvl), model_cnt());
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] rx;
`ifdef ALS_FRAME_CNT_EN
        @(negedge clk_in);
        force dut.frame_cnt_r = 16'hFFFE;
        @(negedge clk_in);
        release dut.frame_cnt_r;
        completed = 16'hFFFE;
`endif
        light_level = 8'h11;
        xfer(16, 6, 0, 8'h00, rx);
        completed++;
        cs_release();
        checks++;
        if (frame_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL wrap_first got %h expected %h", frame_cnt, model_cnt());
        end
        xfer(16, 6, 0, 8'h00, rx);
        completed++;
        cs_release();
        checks++;
        if (frame_cnt !== model_cnt()) begin
            errors++;
            $display("FAIL wrap_second got %h expected %h", frame_cnt, model_cnt());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_level_change();
        test_abort();
        test_overrun();
        test_sdo_latency();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/light_sensor_emu.md
LIGHT_SENSOR_EMU -- requirements
Module: light_sensor_emu

Interface
- REQ-001: Parameter SYNC_STAGES, default 2; flip-flop stages on the CS and SCK synchronizers, legal range 2..3.
- REQ-002: clk_in  input  1  system clock, 100 MHz; all state is in this domain.
- REQ-003: rst_n  input  1  reset; asynchronous assert, active-low.
- REQ-004: CS  input  1  chip select from the SPI master, active-low, asynchronous to clk_in.
- REQ-005: SCK  input  1  serial clock from the master (about 1 MHz), asynchronous to clk_in.
- REQ-006: light_level  input  8  emulated light reading to transmit.
- REQ-007: SDO  output  1  serial data to the master, MSB first.
- REQ-008: sdo_oe  output  1  SDO drive enable; high only while a frame is active.
- REQ-009: frame_done  output  1  one-cycle pulse after the 16th SCK falling edge of a frame.
- REQ-010: frame_abort  output  1  one-cycle pulse when CS rises before a frame completes.
- REQ-011: frame_cnt  output  16  count of completed frames (see Configuration).

Function
- REQ-012: CS and SCK shall each pass through a SYNC_STAGES synchronizer; edges are detected on the synchronized values only.
- REQ-013: Frame format, MSB first, 16 bits: 4'b0000, then light_level[7:0] captured at frame start, then 4'b0000. Example: 8'hA5 gives 16'h0A50.
- REQ-014: The FSM shall have three states: IDLE, SHIFT and HOLD.
- REQ-015: IDLE to SHIFT on a synchronized CS falling edge, with these actions in the same cycle:
  - load the shift register with the frame;
  - set SDO to bit 15;
  - set sdo_oe to 1;
  - clear bit_cnt to 0.
- REQ-016: light_level shall be sampled only on the CS falling edge; changes during a frame do not alter the frame in flight.
- REQ-017: In SHIFT, on each synchronized SCK falling edge:
  - shift left by one, with a zero entering the LSB;
  - SDO takes the new MSB;
  - bit_cnt increments.
- REQ-018: SCK rising edges shall never change SDO; the master samples on rising edges.
- REQ-019: SDO shall update exactly SYNC_STAGES+1 clk_in cycles after an SCK falling edge at the pin.
- REQ-020: When bit_cnt reaches 15 and an SCK falling edge occurs:
  - move to HOLD;
  - pulse frame_done;
  - drive SDO to 0.
- REQ-021: In HOLD, further SCK edges shall be ignored and SDO stays 0; a CS rising edge returns the FSM to IDLE.
- REQ-022: A CS rising edge in SHIFT shall:
  - return the FSM to IDLE;
  - pulse frame_abort;
  - leave frame_cnt unchanged.
- REQ-023: If a CS rising edge and an SCK falling edge are detected in the same cycle, CS has priority.
- REQ-024: In IDLE, SDO shall be 0 and sdo_oe 0.
- REQ-025: Any SCK edge while CS is synchronized high shall be ignored.
- REQ-026: SCK high and low phases shall each be at least SYNC_STAGES+2 clk_in cycles; operation outside this limit is undefined.
- REQ-027: bit_cnt is 4 bits wide.
- REQ-028: frame_cnt is 16 bits and wraps from 16'hFFFF to 16'h0000 without any flag.

Reset
- REQ-029: While rst_n is low, all of the following shall be 0 immediately:
  - the FSM is in IDLE;
  - SDO, sdo_oe, frame_done and frame_abort;
  - frame_cnt, bit_cnt and the shift register;
  - synchronizer flops are set to 1, the idle level of CS.
- REQ-030: Reset asserted mid-frame shall abort silently, with no frame_abort pulse.
- REQ-031: After reset releases with CS already low, no frame shall start until CS is seen high and then falls again.

Configuration
- REQ-032: Macro ALS_FRAME_CNT_EN.
  - Defined: frame_cnt increments by 1 on each frame_done.
  - Undefined: frame_cnt is tied to 16'h0000 and no counter flops are synthesized.
  - In both cases the port list is identical.

Structure
- REQ-033: Shared package als_pkg shall hold:
  - FRAME_BITS=16, LEAD_ZEROS=4, DATA_BITS=8, TRAIL_ZEROS=4;
  - the FSM state encoding (IDLE, SHIFT, HOLD).
- REQ-034: One sub-module, sync_edge, shall provide the parameterized synchronizer with rise and fall pulse outputs; it is instantiated once for CS and once for SCK.

Verification
- REQ-035: light_level=8'hA5; CS low; 16 SCK cycles at 1 MHz -> bits sampled on rising edges equal 16'h0A50; frame_done pulses once; frame_cnt=1 with ALS_FRAME_CNT_EN defined.
- REQ-036: light_level changed from 8'h3C to 8'hFF after the 2nd SCK edge -> frame reads 16'h03C0.
- REQ-037: CS raised after 7 SCK falling edges -> frame_abort pulses once, frame_done does not pulse, FSM is IDLE, sdo_oe=0.
- REQ-038: 20 SCK cycles in one CS-low window with light_level=8'h81 -> first 16 bits are 16'h0810, then SDO stays 0; exactly one frame_done.
- REQ-039: rst_n pulsed low at bit 9 -> outputs are 0 at once; a following full frame with 8'h7E reads 16'h07E0.
- REQ-040: frame_cnt preloaded near wrap, then 2 frames -> value goes 16'hFFFF to 16'h0000; with the macro undefined, frame_cnt stays 0 throughout.
